// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock under a start/done handshake.
// A zero divisor short-circuits to an all-ones quotient with div_by_zero raised.
module seq_divider #(
    parameter int unsigned DVD_W = 16,
    parameter int unsigned DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DVD_W-1:0] q_q, q_d;
    logic [DVS_W-1:0] r_q, r_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d, dbz_d;
    logic [DVS_W:0]   r_shift;
    logic [DVS_W:0]   dvs_ext;

    // Partial remainder with the next dividend bit shifted in, compared at DVS_W+1 bits
    always_comb begin
        r_shift = {r_q, q_q[DVD_W-1]};
        dvs_ext = {1'b0, dvs_q};
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        dbz_d   = div_by_zero;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    r_d     = '0;
                    dvs_d   = divisor;
                    cnt_d   = CNT_W'(DVD_W);
                    dbz_d   = 1'b0;
                    busy_d  = (divisor != '0);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (dvs_q == '0) begin
                    // Zero divisor: finish after one cycle without ever raising busy
                    q_d     = '1;
                    r_d     = '0;
                    dbz_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (r_shift >= dvs_ext) begin
                        r_d = DVS_W'(r_shift - dvs_ext);
                        q_d = {q_q[DVD_W-2:0], 1'b1};
                    end else begin
                        r_d = DVS_W'(r_shift);
                        q_d = {q_q[DVD_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider: results, latency, busy span,
// ignored starts, mid-run reset and continuous restart period.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.DVD_W(16), .DVS_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the capture edge as 1; busyc counts cycles sampled with busy high
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          output int lat, output int busyc);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        busyc = 0;
        while (!done && lat < 40) begin
            if (busy) busyc++;
            tick();
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                            input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                            input int elat, input int ebusy);
        int lat;
        int busyc;
        run_op(dvd, dvs, lat, busyc);
        check({tag, "_lat"},  32'(lat),         32'(elat));
        check({tag, "_q"},    32'(quotient),    32'(eq));
        check({tag, "_r"},    32'(remainder),   32'(er));
        check({tag, "_dbz"},  32'(div_by_zero), 32'(edbz));
        check({tag, "_busy"}, 32'(busyc),       32'(ebusy));
        tick();
        check({tag, "_pulse"}, 32'(done),     32'(0));
        check({tag, "_hold"},  32'(quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        int busyc;
        int dn;
        logic [15:0] rd_dvd;
        logic [7:0]  rd_dvs;
        logic [31:0] recon;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_q",    32'(quotient),    32'(0));
        check("rst_r",    32'(remainder),   32'(0));
        check("rst_busy", 32'(busy),        32'(0));
        check("rst_done", 32'(done),        32'(0));
        check("rst_dbz",  32'(div_by_zero), 32'(0));
        rst = 1'b0;
        tick();

        directed("d1000_7",   16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17, 16);
        directed("d65025",    16'd65025, 8'd255, 16'd255,   8'd0, 1'b0, 17, 16);
        directed("d65535_1",  16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 17, 16);
        directed("d5_9",      16'd5,     8'd9,   16'd0,     8'd5, 1'b0, 17, 16);
        directed("d0_3",      16'd0,     8'd3,   16'd0,     8'd0, 1'b0, 17, 16);
        directed("dz1234",    16'd1234,  8'd0,   16'hFFFF,  8'd0, 1'b1, 2,  0);

        // Results hold in IDLE while inputs wander
        directed("hold_src", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17, 16);
        dividend = 16'd4321;
        divisor  = 8'd13;
        repeat (3) tick();
        check("idle_hold_q",   32'(quotient),    32'(142));
        check("idle_hold_r",   32'(remainder),   32'(6));
        check("idle_hold_dbz", 32'(div_by_zero), 32'(0));

        // Start pulsed mid-run with different operands is ignored
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        repeat (5) begin
            tick();
            lat++;
        end
        dividend = 16'd500;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        lat++;
        start    = 1'b0;
        dividend = 16'hFFFF;
        divisor  = 8'd0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("midstart_lat", 32'(lat),       32'(17));
        check("midstart_q",   32'(quotient),  32'(142));
        check("midstart_r",   32'(remainder), 32'(6));
        dn = 0;
        repeat (25) begin
            tick();
            if (done) dn++;
        end
        check("midstart_extra_done", 32'(dn), 32'(0));

        // Reset mid-run discards the operation
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        check("midrst_q",    32'(quotient),    32'(0));
        check("midrst_r",    32'(remainder),   32'(0));
        check("midrst_busy", 32'(busy),        32'(0));
        check("midrst_done", 32'(done),        32'(0));
        check("midrst_dbz",  32'(div_by_zero), 32'(0));
        rst = 1'b0;
        tick();
        directed("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17, 16);

        // Start held high restarts every 18 cycles
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        lat      = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("held_first_lat", 32'(lat), 32'(17));
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 40);
        start = 1'b0;
        check("held_period", 32'(lat),      32'(18));
        check("held_q",      32'(quotient), 32'(142));
        tick();

        // Randomized identity checks
        for (int i = 0; i < 1000; i++) begin
            rd_dvd = 16'($urandom_range(0, 65535));
            rd_dvs = 8'($urandom_range(1, 255));
            run_op(rd_dvd, rd_dvs, lat, busyc);
            recon = 32'(quotient) * 32'(rd_dvs) + 32'(remainder);
            check("rand_recon", recon, 32'(rd_dvd));
            check("rand_rlt",   32'(remainder < rd_dvs), 32'(1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
